// File: rtl/clock_period_meter.sv
// ============================================================================
// Module   : clock_period_meter
// Brief    : Measures period and high time of a slow square wave in clk_in
//            cycles, with lock and loss-of-signal detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_period_meter #(
    parameter int              SIZE    = 27,
    parameter logic [SIZE-1:0] TIMEOUT = 27'd100000000,
    parameter logic [SIZE-1:0] TOL     = 27'd0
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            sig_in,
    input  logic            clear,
    output logic [SIZE-1:0] period,
    output logic [SIZE-1:0] high_time,
    output logic            meas_valid,
    output logic            locked,
    output logic            no_signal
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;

    localparam logic [SIZE-1:0] c_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] c_TMAX = TIMEOUT - c_ONE;

    logic            s1_q, s2_q, s3_q;
    logic            s1_d, s2_d, s3_d;
    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] hi_lat_q, hi_lat_d;
    logic [SIZE-1:0] prev_q, prev_d;
    logic [SIZE-1:0] period_q, period_d;
    logic [SIZE-1:0] high_q, high_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic            nosig_q, nosig_d;

    logic            w_rise, w_fall, w_tout;
    logic [SIZE-1:0] w_inc, w_diff;

    assign w_rise = s2_q & ~s3_q;
    assign w_fall = ~s2_q & s3_q;
    assign w_tout = (cnt_q == c_TMAX);
    assign w_inc  = cnt_q + c_ONE;
    assign w_diff = (w_inc >= prev_q) ? (w_inc - prev_q) : (prev_q - w_inc);

    always_comb begin
        s1_d     = sig_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        state_d  = state_q;
        hi_lat_d = hi_lat_q;
        prev_d   = prev_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        nosig_d  = nosig_q;
        // Counter restarts on each rise and parks at TIMEOUT-1 so it never wraps
        if (w_rise) begin
            cnt_d = '0;
        end else if (w_tout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = w_inc;
        end

        case (state_q)
            c_IDLE: begin
                if (w_rise) begin
                    state_d = c_ARMED;
                end else if (w_tout) begin
                    nosig_d = 1'b1;
                end
            end
            c_ARMED, c_RUN: begin
                if (w_fall) begin
                    hi_lat_d = w_inc;
                end
                if (w_rise) begin
                    period_d = w_inc;
                    high_d   = hi_lat_q;
                    valid_d  = 1'b1;
                    prev_d   = w_inc;
                    nosig_d  = 1'b0;
                    state_d  = c_RUN;
                    if (state_q == c_RUN) begin
                        locked_d = (w_diff <= TOL);
                    end
                end else if (w_tout) begin
                    nosig_d  = 1'b1;
                    locked_d = 1'b0;
                    state_d  = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // Synchronous clear returns every register to its reset value
        if (clear) begin
            s1_d     = 1'b0;
            s2_d     = 1'b0;
            s3_d     = 1'b0;
            state_d  = c_IDLE;
            cnt_d    = '0;
            hi_lat_d = '0;
            prev_d   = '0;
            period_d = '0;
            high_d   = '0;
            valid_d  = 1'b0;
            locked_d = 1'b0;
            nosig_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
            prev_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            nosig_q  <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            nosig_q  <= nosig_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign no_signal  = nosig_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
// ============================================================================
// Module   : tb_clock_period_meter
// Brief    : Scoreboard bench for clock_period_meter (main and 8-bit instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_period_meter;

    typedef struct {
        int per;
        int hi;
        bit lk;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sig_in, clear;
    logic [26:0] period, high_time;
    logic        meas_valid, locked, no_signal;
    logic        sig8, clear8;
    logic [7:0]  period8, high_time8;
    logic        meas_valid8, locked8, no_signal8;

    exp_t q0[$];
    exp_t q8[$];
    exp_t e0, e8;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mv_prev0 = 1'b0;
    bit   mv_prev8 = 1'b0;

    clock_period_meter #(.SIZE(27), .TIMEOUT(27'd50), .TOL(27'd1)) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .no_signal (no_signal)
    );

    clock_period_meter #(.SIZE(8), .TIMEOUT(8'd200), .TOL(8'd0)) dut8 (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .sig_in    (sig8),
        .clear     (clear8),
        .period    (period8),
        .high_time (high_time8),
        .meas_valid(meas_valid8),
        .locked    (locked8),
        .no_signal (no_signal8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int w, input int p, input int h, input bit l);
        exp_t e;
        e.per = p;
        e.hi  = h;
        e.lk  = l;
        if (w == 0) q0.push_back(e);
        else        q8.push_back(e);
    endtask

    task automatic set_sig(input int w, input logic v);
        if (w == 0) sig_in = v;
        else        sig8   = v;
    endtask

    // Called on a negedge: high for hi cycles, then low for lo cycles
    task automatic pp(input int w, input int hi, input int lo);
        set_sig(w, 1'b1);
        repeat (hi) @(negedge clk);
        set_sig(w, 1'b0);
        repeat (lo) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high"}, high_time, 0);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_nosig"}, no_signal, 0);
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            if (mv_prev0) begin
                n_cmp++;
                n_err++;
                $display("FAIL valid_back_to_back: got 2 consecutive pulses, required 1");
            end
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_valid: got meas_valid=1 period=%0d, required no pulse", period);
            end else begin
                e0 = q0.pop_front();
                chk("sb_period", period, e0.per);
                chk("sb_high", high_time, e0.hi);
                chk("sb_locked", locked, e0.lk);
            end
        end
        mv_prev0 = meas_valid;
    end

    always @(negedge clk) begin
        if (meas_valid8) begin
            if (mv_prev8) begin
                n_cmp++;
                n_err++;
                $display("FAIL valid8_back_to_back: got 2 consecutive pulses, required 1");
            end
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_valid8: got meas_valid=1 period=%0d, required no pulse", period8);
            end else begin
                e8 = q8.pop_front();
                chk("sb8_period", period8, e8.per);
                chk("sb8_high", high_time8, e8.hi);
                chk("sb8_locked", locked8, e8.lk);
            end
        end
        mv_prev8 = meas_valid8;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        clear  = 1'b0;
        sig8   = 1'b0;
        clear8 = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Divider-style 5/5 toggle
        pp(0, 5, 5);
        push(0, 10, 5, 0); pp(0, 5, 5);
        push(0, 10, 5, 1); pp(0, 5, 5);
        push(0, 10, 5, 1); pp(0, 5, 5);

        // Duty cycle 3 high / 7 low
        push(0, 10, 5, 1); pp(0, 3, 7);
        push(0, 10, 3, 1); pp(0, 3, 7);
        push(0, 10, 3, 1); pp(0, 3, 7);

        // Jitter with TOL=1: 11 and 10 keep lock, 13 drops it
        push(0, 10, 3, 1); pp(0, 5, 6);
        push(0, 11, 5, 1); pp(0, 5, 5);
        push(0, 10, 5, 1); pp(0, 5, 8);
        push(0, 13, 5, 0); pp(0, 5, 5);
        push(0, 10, 5, 0); pp(0, 5, 5);

        // Last rise relocks on 10, then sig_in is held low
        push(0, 10, 5, 1);
        set_sig(0, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (meas_valid) got = 1'b1;
        end
        chk("final_rise_seen", got, 1);
        set_sig(0, 1'b0);
        repeat (49) @(negedge clk);
        chk("tout_early_nosig", no_signal, 0);
        chk("tout_early_locked", locked, 1);
        @(negedge clk);
        chk("tout_nosig", no_signal, 1);
        chk("tout_locked", locked, 0);
        chk("tout_period", period, 10);
        chk("tout_high", high_time, 5);
        repeat (20) @(negedge clk);
        chk("tout_hold_nosig", no_signal, 1);

        // Resume: no_signal clears on the second new rise
        pp(0, 5, 5);
        chk("resume_first_nosig", no_signal, 1);
        push(0, 10, 5, 0); pp(0, 5, 5);
        chk("resume_second_nosig", no_signal, 0);
        push(0, 10, 5, 1); pp(0, 5, 5);

        // Async reset mid-period
        push(0, 10, 5, 1);
        set_sig(0, 1'b1);
        repeat (5) @(negedge clk);
        set_sig(0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_locked", locked, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pp(0, 5, 5);
        push(0, 10, 5, 0); pp(0, 5, 5);
        push(0, 10, 5, 1); pp(0, 5, 5);

        // Synchronous clear mid-period
        chk("pre_clr_period", period, 10);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_zero("clear");
        pp(0, 5, 5);
        push(0, 10, 5, 0); pp(0, 5, 5);

        // Saturation on the 8-bit instance: 250-cycle gap
        pp(1, 5, 5);
        push(1, 10, 5, 0); pp(1, 5, 5);
        push(1, 10, 5, 1); pp(1, 5, 5);
        repeat (245) @(negedge clk);
        chk("sat_nosig", no_signal8, 1);
        chk("sat_period", period8, 10);
        chk("sat_locked", locked8, 0);
        pp(1, 5, 5);
        chk("sat_resume_first_nosig", no_signal8, 1);
        push(1, 10, 5, 0); pp(1, 5, 5);
        chk("sat_resume_nosig", no_signal8, 0);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
